// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: forwarding-select encodings,
// the "operand unused" Tuse marker, MDU latency defaults and the
// register-match helper used by the hazard logic.
package mips_pkg;

  // Decode-stage forwarding sources
  localparam logic [1:0] FWD_D_GRF = 2'd0;
  localparam logic [1:0] FWD_D_E   = 2'd1;
  localparam logic [1:0] FWD_D_M   = 2'd2;

  // Execute-stage forwarding sources
  localparam logic [1:0] FWD_E_PIPE = 2'd0;
  localparam logic [1:0] FWD_E_M    = 2'd1;
  localparam logic [1:0] FWD_E_W    = 2'd2;

  // Memory-stage store-data forwarding sources
  localparam logic FWD_M_PIPE = 1'b0;
  localparam logic FWD_M_W    = 1'b1;

  // Tuse value meaning the instruction never reads this operand
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Default MDU busy lengths
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // A stage produces register r when it writes r and r is not $0
  function automatic logic regMatch(input logic [4:0] r,
                                    input logic       regWrite,
                                    input logic [4:0] a3);
    return (r != 5'd0) && regWrite && (a3 == r);
  endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// Multiply/divide busy counter. A start in E loads the operation length;
// the count then runs down to zero. An interrupt in the same cycle
// cancels the start, but a count already running is left alone.
module md_busy_ctr
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic IntReq,
  input  logic E_md_start,
  input  logic E_md_div,
  output logic md_busy
);

  localparam int MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CntW      = $clog2(MaxCycles + 1);

  logic            startOk;
  logic [CntW-1:0] busyCnt_q;
  logic [CntW-1:0] busyCnt_d;

  assign startOk = E_md_start & ~IntReq;

  // A new start reloads the counter ahead of the decrement, so back-to-back issues chain
  always_comb begin
    busyCnt_d = busyCnt_q;
    if (startOk) begin
      busyCnt_d = E_md_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
    end else if (busyCnt_q != '0) begin
      busyCnt_d = busyCnt_q - 1'b1;
    end
  end

  // Count register, cleared at once by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busyCnt_q <= '0;
    end else begin
      busyCnt_q <= busyCnt_d;
    end
  end

  // Busy already in the issue cycle so a dependent mfhi/mflo in D stalls immediately
  assign md_busy = (busyCnt_q != '0) | startOk;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: decode-stage stall/bubble decision,
// forwarding selects for D, E and M, MDU busy tracking and a
// saturating count of stall cycles.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IntReq,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_Tuse_rs,
  input  logic [1:0]  D_Tuse_rt,
  input  logic        D_md,
  input  logic [4:0]  E_rs,
  input  logic [4:0]  E_rt,
  input  logic [4:0]  M_rt,
  input  logic [4:0]  E_A3,
  input  logic [4:0]  M_A3,
  input  logic [4:0]  W_A3,
  input  logic        E_RegWrite,
  input  logic        M_RegWrite,
  input  logic        W_RegWrite,
  input  logic [1:0]  E_T_new,
  input  logic [1:0]  M_T_new,
  input  logic        E_md_start,
  input  logic        E_md_div,
  output logic        stall,
  output logic        flush_E,
  output logic [1:0]  fwd_D_rs,
  output logic [1:0]  fwd_D_rt,
  output logic [1:0]  fwd_E_rs,
  output logic [1:0]  fwd_E_rt,
  output logic        fwd_M_rt,
  output logic        md_busy,
  output logic [31:0] stall_count
);

  logic        eMatchDrs, mMatchDrs, eMatchDrt, mMatchDrt;
  logic        dataStall, mdStall;
  logic [31:0] stallCount_q;
  logic [31:0] stallCount_d;

  md_busy_ctr #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_ctr (
    .clk        (clk),
    .reset      (reset),
    .IntReq     (IntReq),
    .E_md_start (E_md_start),
    .E_md_div   (E_md_div),
    .md_busy    (md_busy)
  );

  assign eMatchDrs = regMatch(D_rs, E_RegWrite, E_A3);
  assign mMatchDrs = regMatch(D_rs, M_RegWrite, M_A3);
  assign eMatchDrt = regMatch(D_rt, E_RegWrite, E_A3);
  assign mMatchDrt = regMatch(D_rt, M_RegWrite, M_A3);

  // An unused operand carries Tuse 3, which no T_new can exceed
  assign dataStall = (eMatchDrs && (E_T_new > D_Tuse_rs)) ||
                     (mMatchDrs && (M_T_new > D_Tuse_rs)) ||
                     (eMatchDrt && (E_T_new > D_Tuse_rt)) ||
                     (mMatchDrt && (M_T_new > D_Tuse_rt));
  assign mdStall   = D_md & md_busy;

  // The exception flush owns the pipeline while IntReq is up
  assign stall   = (dataStall | mdStall) & ~IntReq;
  assign flush_E = stall;

  // Nearest ready producer wins; W into D is handled by GRF write-before-read
  always_comb begin
    fwd_D_rs = FWD_D_GRF;
    fwd_D_rt = FWD_D_GRF;
    fwd_E_rs = FWD_E_PIPE;
    fwd_E_rt = FWD_E_PIPE;
    fwd_M_rt = FWD_M_PIPE;

    if (eMatchDrs && (E_T_new == 2'd0)) fwd_D_rs = FWD_D_E;
    else if (mMatchDrs && (M_T_new == 2'd0)) fwd_D_rs = FWD_D_M;

    if (eMatchDrt && (E_T_new == 2'd0)) fwd_D_rt = FWD_D_E;
    else if (mMatchDrt && (M_T_new == 2'd0)) fwd_D_rt = FWD_D_M;

    if (regMatch(E_rs, M_RegWrite, M_A3) && (M_T_new == 2'd0)) fwd_E_rs = FWD_E_M;
    else if (regMatch(E_rs, W_RegWrite, W_A3)) fwd_E_rs = FWD_E_W;

    if (regMatch(E_rt, M_RegWrite, M_A3) && (M_T_new == 2'd0)) fwd_E_rt = FWD_E_M;
    else if (regMatch(E_rt, W_RegWrite, W_A3)) fwd_E_rt = FWD_E_W;

    if (regMatch(M_rt, W_RegWrite, W_A3)) fwd_M_rt = FWD_M_W;
  end

  // Stall counter saturates instead of wrapping
  always_comb begin
    stallCount_d = stallCount_q;
    if (stall && (stallCount_q != 32'hFFFF_FFFF)) begin
      stallCount_d = stallCount_q + 32'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCount_q <= 32'd0;
    end else begin
      stallCount_q <= stallCount_d;
    end
  end

  assign stall_count = stallCount_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Each step drives one cycle of pipeline
// state, pushes the expected outputs to a scoreboard queue and pops them
// at the falling edge to compare against the DUT.
module tb_hazard_ctrl;

  typedef struct {
    logic        stall;
    logic [1:0]  fdrs;
    logic [1:0]  fdrt;
    logic [1:0]  fers;
    logic [1:0]  fert;
    logic        fmrt;
    logic        busy;
    logic [31:0] cnt;
  } expT;

  logic        clk;
  logic        reset;
  logic        IntReq;
  logic [4:0]  D_rs, D_rt;
  logic [1:0]  D_Tuse_rs, D_Tuse_rt;
  logic        D_md;
  logic [4:0]  E_rs, E_rt, M_rt;
  logic [4:0]  E_A3, M_A3, W_A3;
  logic        E_RegWrite, M_RegWrite, W_RegWrite;
  logic [1:0]  E_T_new, M_T_new;
  logic        E_md_start, E_md_div;
  logic        stall, flush_E;
  logic [1:0]  fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt;
  logic        fwd_M_rt;
  logic        md_busy;
  logic [31:0] stall_count;

  expT         expQ[$];
  string       tagQ[$];
  int          vectors;
  int          miscompares;
  logic [31:0] expStallCount;

  hazard_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .IntReq      (IntReq),
    .D_rs        (D_rs),
    .D_rt        (D_rt),
    .D_Tuse_rs   (D_Tuse_rs),
    .D_Tuse_rt   (D_Tuse_rt),
    .D_md        (D_md),
    .E_rs        (E_rs),
    .E_rt        (E_rt),
    .M_rt        (M_rt),
    .E_A3        (E_A3),
    .M_A3        (M_A3),
    .W_A3        (W_A3),
    .E_RegWrite  (E_RegWrite),
    .M_RegWrite  (M_RegWrite),
    .W_RegWrite  (W_RegWrite),
    .E_T_new     (E_T_new),
    .M_T_new     (M_T_new),
    .E_md_start  (E_md_start),
    .E_md_div    (E_md_div),
    .stall       (stall),
    .flush_E     (flush_E),
    .fwd_D_rs    (fwd_D_rs),
    .fwd_D_rt    (fwd_D_rt),
    .fwd_E_rs    (fwd_E_rs),
    .fwd_E_rt    (fwd_E_rt),
    .fwd_M_rt    (fwd_M_rt),
    .md_busy     (md_busy),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clearInputs();
    IntReq     = 1'b0;
    D_rs       = 5'd0;
    D_rt       = 5'd0;
    D_Tuse_rs  = 2'd3;
    D_Tuse_rt  = 2'd3;
    D_md       = 1'b0;
    E_rs       = 5'd0;
    E_rt       = 5'd0;
    M_rt       = 5'd0;
    E_A3       = 5'd0;
    M_A3       = 5'd0;
    W_A3       = 5'd0;
    E_RegWrite = 1'b0;
    M_RegWrite = 1'b0;
    W_RegWrite = 1'b0;
    E_T_new    = 2'd0;
    M_T_new    = 2'd0;
    E_md_start = 1'b0;
    E_md_div   = 1'b0;
  endtask

  // New cycle: inputs change shortly after the rising edge
  task automatic stepBegin();
    @(posedge clk);
    #1;
    clearInputs();
  endtask

  task automatic applyStimulus(input string tag, input logic st,
                               input logic [1:0] fdrs, input logic [1:0] fdrt,
                               input logic [1:0] fers, input logic [1:0] fert,
                               input logic fmrt, input logic busy);
    expT e;
    e.stall = st;
    e.fdrs  = fdrs;
    e.fdrt  = fdrt;
    e.fers  = fers;
    e.fert  = fert;
    e.fmrt  = fmrt;
    e.busy  = busy;
    e.cnt   = expStallCount;
    expQ.push_back(e);
    tagQ.push_back(tag);
    if (st && (expStallCount != 32'hFFFF_FFFF)) expStallCount = expStallCount + 32'd1;
  endtask

  task automatic checkOne(input string tag, input string field,
                          input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, field, observed, expected);
    end
  endtask

  task automatic checkOutput(input bit waitEdge);
    expT   e;
    string tag;
    if (waitEdge) @(negedge clk);
    vectors++;
    assert (expQ.size() != 0)
    else begin
      miscompares++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
    end
    if (expQ.size() != 0) begin
      e   = expQ.pop_front();
      tag = tagQ.pop_front();
      checkOne(tag, "stall",       32'(stall),    32'(e.stall));
      checkOne(tag, "flush_E",     32'(flush_E),  32'(e.stall));
      checkOne(tag, "fwd_D_rs",    32'(fwd_D_rs), 32'(e.fdrs));
      checkOne(tag, "fwd_D_rt",    32'(fwd_D_rt), 32'(e.fdrt));
      checkOne(tag, "fwd_E_rs",    32'(fwd_E_rs), 32'(e.fers));
      checkOne(tag, "fwd_E_rt",    32'(fwd_E_rt), 32'(e.fert));
      checkOne(tag, "fwd_M_rt",    32'(fwd_M_rt), 32'(e.fmrt));
      checkOne(tag, "md_busy",     32'(md_busy),  32'(e.busy));
      checkOne(tag, "stall_count", stall_count,   e.cnt);
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    expStallCount = 32'd0;
    reset         = 1'b1;
    clearInputs();

    // Reset state
    #3;
    applyStimulus("reset", 0, 0, 0, 0, 0, 0, 0);
    checkOutput(0);
    @(negedge clk);
    reset = 1'b0;

    // lw in E, dependent add in D: one stall
    stepBegin();
    E_A3 = 5'd8; E_RegWrite = 1; E_T_new = 2'd2; D_rs = 5'd8; D_Tuse_rs = 2'd1;
    applyStimulus("lwE", 1, 0, 0, 0, 0, 0, 0);
    checkOutput(1);

    // lw in M: no stall
    stepBegin();
    M_A3 = 5'd8; M_RegWrite = 1; M_T_new = 2'd1; D_rs = 5'd8; D_Tuse_rs = 2'd1;
    applyStimulus("lwM", 0, 0, 0, 0, 0, 0, 0);
    checkOutput(1);

    // add in E, lw in W: forward from W to E and to M store data
    stepBegin();
    W_A3 = 5'd8; W_RegWrite = 1; E_rs = 5'd8; M_rt = 5'd8;
    applyStimulus("lwW", 0, 0, 0, 2, 0, 1, 0);
    checkOutput(1);

    // $0 never matches
    stepBegin();
    E_A3 = 5'd0; E_RegWrite = 1; E_T_new = 2'd2; D_rs = 5'd0; D_Tuse_rs = 2'd0;
    applyStimulus("zeroReg", 0, 0, 0, 0, 0, 0, 0);
    checkOutput(1);

    // M beats W for E forwarding; M also feeds D
    stepBegin();
    M_A3 = 5'd5; W_A3 = 5'd5; M_RegWrite = 1; W_RegWrite = 1; M_T_new = 2'd0;
    E_rs = 5'd5; D_rt = 5'd5;
    applyStimulus("prioMW", 0, 0, 2, 1, 0, 0, 0);
    checkOutput(1);

    // Without M write, W forwards
    stepBegin();
    M_A3 = 5'd5; W_A3 = 5'd5; M_RegWrite = 0; W_RegWrite = 1; M_T_new = 2'd0;
    E_rs = 5'd5; D_rt = 5'd5;
    applyStimulus("prioW", 0, 0, 0, 2, 0, 0, 0);
    checkOutput(1);

    // E beats M for D forwarding when both are ready
    stepBegin();
    E_A3 = 5'd9; E_RegWrite = 1; E_T_new = 2'd0; M_A3 = 5'd9; M_RegWrite = 1; M_T_new = 2'd0;
    D_rt = 5'd9; D_Tuse_rt = 2'd0; E_rt = 5'd9;
    applyStimulus("prioEM", 0, 0, 1, 0, 1, 0, 0);
    checkOutput(1);

    // Stall from M on rt with Tuse 0
    stepBegin();
    M_A3 = 5'd10; M_RegWrite = 1; M_T_new = 2'd1; D_rt = 5'd10; D_Tuse_rt = 2'd0;
    applyStimulus("stallMrt", 1, 0, 0, 0, 0, 0, 0);
    checkOutput(1);

    // div then mflo: 11 busy/stall cycles, then release
    stepBegin();
    E_md_start = 1; E_md_div = 1; D_md = 1;
    applyStimulus("divStart", 1, 0, 0, 0, 0, 0, 1);
    checkOutput(1);
    for (int i = 0; i < 10; i++) begin
      stepBegin();
      D_md = 1;
      applyStimulus("divBusy", 1, 0, 0, 0, 0, 0, 1);
      checkOutput(1);
    end
    stepBegin();
    D_md = 1;
    applyStimulus("divDone", 0, 0, 0, 0, 0, 0, 0);
    checkOutput(1);

    // IntReq masks the data stall and the MDU start
    stepBegin();
    IntReq = 1; E_A3 = 5'd8; E_RegWrite = 1; E_T_new = 2'd2; D_rs = 5'd8; D_Tuse_rs = 2'd1;
    E_md_start = 1; D_md = 1;
    applyStimulus("intReq", 0, 0, 0, 0, 0, 0, 0);
    checkOutput(1);
    stepBegin();
    D_md = 1;
    applyStimulus("intNoLoad", 0, 0, 0, 0, 0, 0, 0);
    checkOutput(1);

    // mult, then div issued in the cycle the count reaches 1
    stepBegin();
    E_md_start = 1;
    applyStimulus("multStart", 0, 0, 0, 0, 0, 0, 1);
    checkOutput(1);
    for (int i = 0; i < 4; i++) begin
      stepBegin();
      applyStimulus("multBusy", 0, 0, 0, 0, 0, 0, 1);
      checkOutput(1);
    end
    stepBegin();
    E_md_start = 1; E_md_div = 1;
    applyStimulus("b2bDiv", 0, 0, 0, 0, 0, 0, 1);
    checkOutput(1);
    for (int i = 0; i < 10; i++) begin
      stepBegin();
      applyStimulus("b2bBusy", 0, 0, 0, 0, 0, 0, 1);
      checkOutput(1);
    end
    stepBegin();
    applyStimulus("b2bDone", 0, 0, 0, 0, 0, 0, 0);
    checkOutput(1);

    // Reset in the middle of a div clears everything without a clock edge
    stepBegin();
    E_md_start = 1; E_md_div = 1; D_md = 1;
    applyStimulus("div2Start", 1, 0, 0, 0, 0, 0, 1);
    checkOutput(1);
    for (int i = 0; i < 3; i++) begin
      stepBegin();
      D_md = 1;
      applyStimulus("div2Busy", 1, 0, 0, 0, 0, 0, 1);
      checkOutput(1);
    end
    stepBegin();
    D_md = 1;
    #2;
    reset = 1'b1;
    #1;
    expStallCount = 32'd0;
    applyStimulus("asyncRst", 0, 0, 0, 0, 0, 0, 0);
    checkOutput(0);
    @(negedge clk);
    reset = 1'b0;

    // Three stall cycles then the count reads 3
    for (int i = 0; i < 3; i++) begin
      stepBegin();
      E_A3 = 5'd12; E_RegWrite = 1; E_T_new = 2'd1; D_rs = 5'd12; D_Tuse_rs = 2'd0;
      applyStimulus("cntStall", 1, 0, 0, 0, 0, 0, 0);
      checkOutput(1);
    end
    stepBegin();
    applyStimulus("cntThree", 0, 0, 0, 0, 0, 0, 0);
    checkOutput(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
